// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   mem_op_e       : operation class issued by decode (none / load / store)
//   mem_rd_e       : load flavour (byte/half/word, signed or unsigned)
//   MEM_WR_*       : store byte masks, byte-lane-0 based
//   lsu_state_e    : FSM states of the unit
//   is_misaligned  : alignment rule shared by every access type
//   lane_replicate : spreads narrow store data across all four byte lanes
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [2:0] {
        MEM_RD_LB  = 3'd0,
        MEM_RD_LH  = 3'd1,
        MEM_RD_LW  = 3'd2,
        MEM_RD_LBU = 3'd4,
        MEM_RD_LHU = 3'd5
    } mem_rd_e;

    localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
    localparam logic [3:0] MEM_WR_HALF = 4'b0011;
    localparam logic [3:0] MEM_WR_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Halfwords need an even address, words a multiple of four; bytes are
    // always aligned. Any op other than a store is treated as a load.
    function automatic logic is_misaligned(input logic [1:0] op,
                                           input logic [2:0] rd_type,
                                           input logic [3:0] wr_mask,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (op == MEM_OP_STORE) begin
            case (wr_mask)
                MEM_WR_HALF: mis = offset[0];
                MEM_WR_WORD: mis = (offset != 2'b00);
                default:     mis = 1'b0;
            endcase
        end else begin
            case (rd_type)
                MEM_RD_LH, MEM_RD_LHU: mis = offset[0];
                MEM_RD_LW:             mis = (offset != 2'b00);
                default:               mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

    // The strobes pick the live lane, so the data only has to be present
    // in every lane the narrow store could land on.
    function automatic logic [31:0] lane_replicate(input logic [3:0]  wr_mask,
                                                   input logic [31:0] data);
        logic [31:0] wdata;
        case (wr_mask)
            MEM_WR_BYTE: wdata = {4{data[7:0]}};
            MEM_WR_HALF: wdata = {2{data[15:0]}};
            default:     wdata = data;
        endcase
        return wdata;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner.
//   rdata     in  32  raw word from the data bus
//   offset    in  2   byte offset of the access inside the word
//   read_type in  3   mem_rd_e load flavour
//   result    out 32  selected byte/half/word, sign- or zero-extended
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  read_type,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword accesses are known aligned, so offset[1] alone picks the half.
    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (read_type)
            MEM_RD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEM_RD_LBU: result = {24'h0, byte_sel};
            MEM_RD_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEM_RD_LHU: result = {16'h0, half_sel};
            default:    result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/ack data-bus transaction per decoded memory
// op and stalls the core until it finishes.
//   clk, rst_n          core clock, asynchronous active-low reset
//   start, mem_op       EX-stage valid and operation class
//   mem_read_type       load flavour, mem_write_mask store byte mask
//   addr, store_data    effective address and rs2 value
//   stall               hold the pipeline
//   done                one-cycle completion pulse
//   load_data           extended load result, valid with done
//   misaligned, bus_err qualify done
//   bus_req/we/addr/wdata/wstrb, bus_ack/rdata   data-bus handshake
// TIMEOUT: cycles spent in REQ without bus_ack before bus_err; 0 disables it.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_read_type,
    input  logic [3:0]  mem_write_mask,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = 16;

    lsu_state_e        state;
    lsu_state_e        next_state;

    logic              is_store_q;
    logic [2:0]        rd_type_q;
    logic [3:0]        wr_mask_q;
    logic [31:0]       addr_q;
    logic [31:0]       sd_q;
    logic [31:0]       load_data_q;
    logic              misaligned_q;
    logic              bus_err_q;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              misaligned_now;
    logic              timeout_hit;
    logic [31:0]       aligned_rdata;

    load_align u_load_align (
        .rdata     (bus_rdata),
        .offset    (addr_q[1:0]),
        .read_type (rd_type_q),
        .result    (aligned_rdata)
    );

    always_comb begin
        accept         = (state == ST_IDLE) && start && (mem_op != MEM_OP_NONE);
        misaligned_now = is_misaligned(mem_op, mem_read_type, mem_write_mask, addr[1:0]);
        timeout_hit    = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    end

    // Misaligned accesses skip the bus entirely and report straight away.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = misaligned_now ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ack || timeout_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The op is captured at accept so the bus fields stay stable for the
    // whole request even though the EX stage inputs move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q   <= 1'b0;
            rd_type_q    <= 3'd0;
            wr_mask_q    <= 4'd0;
            addr_q       <= 32'd0;
            sd_q         <= 32'd0;
            load_data_q  <= 32'd0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        is_store_q   <= (mem_op == MEM_OP_STORE);
                        rd_type_q    <= mem_read_type;
                        wr_mask_q    <= mem_write_mask;
                        addr_q       <= addr;
                        sd_q         <= store_data;
                        load_data_q  <= 32'd0;
                        misaligned_q <= misaligned_now;
                        bus_err_q    <= 1'b0;
                        cnt          <= '0;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        load_data_q <= is_store_q ? 32'd0 : aligned_rdata;
                    end else if (timeout_hit) begin
                        bus_err_q   <= 1'b1;
                        load_data_q <= 32'd0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Every handshake output decodes from the registered state, so reset
    // drops bus_req immediately and no combinational path reaches the bus.
    always_comb begin
        bus_req    = (state == ST_REQ);
        bus_we     = bus_req && is_store_q;
        bus_addr   = {addr_q[31:2], 2'b00};
        bus_wdata  = lane_replicate(wr_mask_q, sd_q);
        bus_wstrb  = bus_we ? (wr_mask_q << addr_q[1:0]) : 4'b0000;
        done       = (state == ST_DONE);
        misaligned = done && misaligned_q;
        bus_err    = done && bus_err_q;
        load_data  = load_data_q;
        stall      = accept || bus_req;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed transactions against a
// transaction-level reference model, plus literal expectations per scenario.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TIMEOUT_CYCLES = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mem_op;
    logic [2:0]  mem_read_type;
    logic [3:0]  mem_write_mask;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    load_store_unit #(.TIMEOUT(TIMEOUT_CYCLES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mem_op         (mem_op),
        .mem_read_type  (mem_read_type),
        .mem_write_mask (mem_write_mask),
        .addr           (addr),
        .store_data     (store_data),
        .stall          (stall),
        .done           (done),
        .load_data      (load_data),
        .misaligned     (misaligned),
        .bus_err        (bus_err),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model: one outstanding transaction, phase 0 idle, 1 on the
    // bus, 2 reporting. Data is derived from access size and byte offset.
    int          m_phase  = 0;
    bit          m_store  = 0;
    bit          m_signed = 0;
    int          m_size   = 4;
    int          m_waits  = 0;
    logic [31:0] m_addr   = 0;
    logic [31:0] m_wdata  = 0;
    logic [3:0]  m_wstrb  = 0;
    logic [31:0] m_result = 0;
    bit          m_mis    = 0;
    bit          m_err    = 0;

    function automatic logic [31:0] model_extract(input logic [31:0] word,
                                                  input logic [31:0] a,
                                                  input int size, input bit sgn);
        longint v;
        longint span;
        int     off;
        off  = int'(a % 32'd4);
        span = longint'(1) << (8 * size);
        v    = (longint'(word) >> (8 * off)) % span;
        if (sgn && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int off;
        if (!rst_n) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (start && mem_op != MEM_OP_NONE) begin
                        m_store = (mem_op == MEM_OP_STORE);
                        if (m_store)
                            m_size = (mem_write_mask == 4'b0001) ? 1 :
                                     (mem_write_mask == 4'b0011) ? 2 : 4;
                        else
                            m_size = (mem_read_type == MEM_RD_LB || mem_read_type == MEM_RD_LBU) ? 1 :
                                     (mem_read_type == MEM_RD_LH || mem_read_type == MEM_RD_LHU) ? 2 : 4;
                        m_signed = !m_store && (mem_read_type == MEM_RD_LB || mem_read_type == MEM_RD_LH);
                        m_addr   = addr;
                        off      = int'(addr % 32'd4);
                        m_wstrb  = 4'((int'(mem_write_mask) * (1 << off)) % 16);
                        for (int i = 0; i < 4; i++)
                            m_wdata[8*i +: 8] = store_data[8*(i % m_size) +: 8];
                        m_mis    = (int'(addr % 32'd4) % m_size) != 0;
                        m_err    = 0;
                        m_result = 0;
                        m_waits  = 0;
                        m_phase  = m_mis ? 2 : 1;
                    end
                end
                1: begin
                    if (bus_ack) begin
                        m_result = m_store ? 32'd0 : model_extract(bus_rdata, m_addr, m_size, m_signed);
                        m_phase  = 2;
                    end else begin
                        m_waits++;
                        if (m_waits == TIMEOUT_CYCLES) begin
                            m_err    = 1;
                            m_result = 0;
                            m_phase  = 2;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Observations captured for the literal per-scenario expectations.
    bit          req_seen   = 0;
    int          done_count = 0;
    int          done_cyc   = 0;
    int          last_t0    = 0;
    logic        t0_stall   = 0;
    logic [31:0] cap_addr   = 0;
    logic [31:0] cap_wdata  = 0;
    logic [3:0]  cap_wstrb  = 0;
    logic [31:0] cap_ld     = 0;
    logic        cap_mis    = 0;
    logic        cap_err    = 0;

    always @(negedge clk) begin
        bit e_req;
        bit e_done;
        bit e_stall;
        e_req   = (m_phase == 1);
        e_done  = (m_phase == 2);
        e_stall = e_req || (m_phase == 0 && start && mem_op != MEM_OP_NONE);
        check_output("stall", {31'd0, stall}, {31'd0, e_stall});
        check_output("bus_req", {31'd0, bus_req}, {31'd0, e_req});
        check_output("done", {31'd0, done}, {31'd0, e_done});
        if (e_req) begin
            check_output("bus_addr", bus_addr, m_addr & 32'hFFFF_FFFC);
            check_output("bus_we", {31'd0, bus_we}, {31'd0, m_store});
            check_output("bus_wstrb", {28'd0, bus_wstrb}, m_store ? {28'd0, m_wstrb} : 32'd0);
            if (m_store) check_output("bus_wdata", bus_wdata, m_wdata);
        end
        if (e_done) begin
            check_output("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
            check_output("bus_err", {31'd0, bus_err}, {31'd0, m_err});
            if (m_err || (!m_store && !m_mis)) check_output("load_data", load_data, m_result);
        end
        if (bus_req) begin
            req_seen  = 1;
            cap_addr  = bus_addr;
            cap_wdata = bus_wdata;
            cap_wstrb = bus_wstrb;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
            cap_ld   = load_data;
            cap_mis  = misaligned;
            cap_err  = bus_err;
        end
    end

    // Issues one op for a single cycle and serves the bus. ack_delay counts
    // bus_req cycles before acking; negative withholds the ack entirely.
    task automatic apply_stimulus(input logic [1:0] op, input logic [2:0] rt,
                                  input logic [3:0] mask, input logic [31:0] a,
                                  input logic [31:0] sd, input int ack_delay,
                                  input logic [31:0] rdata, input bit start_in_done);
        int waited;
        int req_cycles;
        waited     = 0;
        req_cycles = 0;
        req_seen   = 0;
        start          = 1'b1;
        mem_op         = op;
        mem_read_type  = rt;
        mem_write_mask = mask;
        addr           = a;
        store_data     = sd;
        last_t0        = cyc;
        #1 t0_stall = stall;
        @(posedge clk); #1;
        start  = 1'b0;
        mem_op = MEM_OP_NONE;
        if (op == MEM_OP_NONE) begin
            @(posedge clk); #1;
            return;
        end
        while (!done && waited < 40) begin
            if (bus_req && ack_delay >= 0 && req_cycles == ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            if (bus_req) req_cycles++;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            waited++;
        end
        check_output("done_seen", {31'd0, done}, 32'd1);
        if (start_in_done) begin
            start         = 1'b1;
            mem_op        = MEM_OP_LOAD;
            mem_read_type = MEM_RD_LW;
            addr          = 32'h0000_0800;
            @(posedge clk); #1;
            start  = 1'b0;
            mem_op = MEM_OP_NONE;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int dc;
        rst_n          = 1'b0;
        start          = 1'b0;
        mem_op         = MEM_OP_NONE;
        mem_read_type  = MEM_RD_LW;
        mem_write_mask = 4'b0000;
        addr           = 32'd0;
        store_data     = 32'd0;
        bus_ack        = 1'b0;
        bus_rdata      = 32'd0;

        #3;
        check_output("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check_output("rst_stall", {31'd0, stall}, 32'd0);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_load_data", load_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // sb to offset 1, zero-wait ack
        apply_stimulus(MEM_OP_STORE, MEM_RD_LW, MEM_WR_BYTE, 32'h0000_0101, 32'h1234_5678, 0, 32'h0, 0);
        check_output("sb_wstrb", {28'd0, cap_wstrb}, 32'h0000_0002);
        check_output("sb_wdata", cap_wdata, 32'h7878_7878);
        check_output("sb_addr", cap_addr, 32'h0000_0100);
        check_output("sb_latency", done_cyc - last_t0, 32'd2);

        // lh / lhu from the upper half
        apply_stimulus(MEM_OP_LOAD, MEM_RD_LH, 4'b0000, 32'h0000_0202, 32'h0, 1, 32'h8001_5A5A, 0);
        check_output("lh_data", cap_ld, 32'hFFFF_8001);
        check_output("lh_latency", done_cyc - last_t0, 32'd3);
        apply_stimulus(MEM_OP_LOAD, MEM_RD_LHU, 4'b0000, 32'h0000_0202, 32'h0, 0, 32'h8001_5A5A, 0);
        check_output("lhu_data", cap_ld, 32'h0000_8001);

        // misaligned lw never touches the bus
        apply_stimulus(MEM_OP_LOAD, MEM_RD_LW, 4'b0000, 32'h0000_0302, 32'h0, 0, 32'h0, 0);
        check_output("mis_no_req", {31'd0, req_seen}, 32'd0);
        check_output("mis_flag", {31'd0, cap_mis}, 32'd1);
        check_output("mis_latency", done_cyc - last_t0, 32'd1);
        check_output("mis_t0_stall", {31'd0, t0_stall}, 32'd1);

        // lb with the ack withheld runs into the timeout
        apply_stimulus(MEM_OP_LOAD, MEM_RD_LB, 4'b0000, 32'h0000_0403, 32'h0, -1, 32'h0, 0);
        check_output("to_err", {31'd0, cap_err}, 32'd1);
        check_output("to_data", cap_ld, 32'd0);
        check_output("to_latency", done_cyc - last_t0, 32'd17);
        check_output("to_req_after", {31'd0, bus_req}, 32'd0);

        // further lanes and wait states
        apply_stimulus(MEM_OP_STORE, MEM_RD_LW, MEM_WR_HALF, 32'h0000_0206, 32'h1234_ABCD, 2, 32'h0, 0);
        check_output("sh_wstrb", {28'd0, cap_wstrb}, 32'h0000_000C);
        check_output("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        apply_stimulus(MEM_OP_STORE, MEM_RD_LW, MEM_WR_WORD, 32'h0000_0500, 32'hCAFE_F00D, 3, 32'h0, 0);
        check_output("sw_wdata", cap_wdata, 32'hCAFE_F00D);
        apply_stimulus(MEM_OP_LOAD, MEM_RD_LBU, 4'b0000, 32'h0000_0103, 32'h0, 0, 32'hF0E0_D0C0, 0);
        check_output("lbu_data", cap_ld, 32'h0000_00F0);
        apply_stimulus(MEM_OP_LOAD, MEM_RD_LB, 4'b0000, 32'h0000_0103, 32'h0, 1, 32'hF0E0_D0C0, 0);
        check_output("lb_data", cap_ld, 32'hFFFF_FFF0);
        apply_stimulus(MEM_OP_STORE, MEM_RD_LW, MEM_WR_HALF, 32'h0000_0203, 32'h0000_1111, 0, 32'h0, 0);
        check_output("sh_mis_flag", {31'd0, cap_mis}, 32'd1);

        // reset in the middle of a request
        dc = done_count;
        start          = 1'b1;
        mem_op         = MEM_OP_LOAD;
        mem_read_type  = MEM_RD_LW;
        addr           = 32'h0000_0700;
        @(posedge clk); #1;
        start  = 1'b0;
        mem_op = MEM_OP_NONE;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        repeat (2) @(posedge clk);
        #1 bus_ack = 1'b0;
        @(posedge clk); #1;
        check_output("rst_no_done", done_count, dc);

        // ignored starts: mem_op NONE, and a start while reporting
        dc = done_count;
        apply_stimulus(MEM_OP_NONE, MEM_RD_LW, 4'b0000, 32'h0000_0900, 32'h0, 0, 32'h0, 0);
        check_output("none_stall", {31'd0, t0_stall}, 32'd0);
        check_output("none_no_req", {31'd0, req_seen}, 32'd0);
        check_output("none_no_done", done_count, dc);
        apply_stimulus(MEM_OP_LOAD, MEM_RD_LW, 4'b0000, 32'h0000_0A00, 32'h0, 0, 32'h0BAD_BEEF, 1);
        req_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check_output("done_start_no_req", {31'd0, req_seen}, 32'd0);
        check_output("done_start_one_done", done_count, dc + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
